// File: rtl/channel_accum_sched.sv
// Time-shares one external 16-input adder tree across input-channel groups,
// accumulating cfg_groups tree results into a single output-pixel sum.
module channel_accum_sched #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int GRP_W     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [GRP_W-1:0]       cfg_groups,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*BIT_WIDTH-1:0] in_data,
  output logic [16*BIT_WIDTH-1:0] tree_in,
  input  logic [OUT_WIDTH-1:0]   tree_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  // Handshakes: a beat moves when in_valid && in_ready on a rising edge; a
  // result moves when out_valid && out_ready. Neither side may withdraw valid.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [GRP_W-1:0]     grp_cnt;
  logic [GRP_W-1:0]     grp_tgt;
  logic [ACC_WIDTH-1:0] tree_ext;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [GRP_W-1:0]     eff_tgt;
  logic                 in_fire;
  logic                 out_fire;
  logic                 last_beat;

  assign tree_in   = in_data;
  assign tree_ext  = ACC_WIDTH'($signed(tree_sum));
  assign acc_sum   = acc + tree_ext;
  assign eff_tgt   = (cfg_groups == '0) ? GRP_W'(1) : cfg_groups;

  assign in_ready  = (state != DONE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // grp_cnt counts accepted beats, so the beat now arriving is number grp_cnt+1.
  assign last_beat = (GRP_W'(grp_cnt + GRP_W'(1)) == grp_tgt);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_fire) state_next = (eff_tgt == GRP_W'(1)) ? DONE : ACCUM;
      ACCUM:   if (in_fire && last_beat) state_next = DONE;
      DONE:    if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      grp_cnt  <= '0;
      grp_tgt  <= GRP_W'(1);
      out_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_fire) begin
            grp_tgt <= eff_tgt;
            acc     <= tree_ext;
            grp_cnt <= GRP_W'(1);
            if (eff_tgt == GRP_W'(1)) out_data <= tree_ext;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc     <= acc_sum;
            grp_cnt <= GRP_W'(grp_cnt + GRP_W'(1));
            if (last_beat) out_data <= acc_sum;
          end
        end
        DONE: begin
          // out_data is left holding the last result; only acc/count are cleared.
          if (out_fire) begin
            acc     <= '0;
            grp_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/channel_accum_sched.md
Name: channel_accum_sched

Overview:
- Sequencer that time-shares one external 16-input channel adder tree (`add_channel_16`, OUT_WIDTH result) across input-channel groups.
- Accepts a stream of 16-lane beats and drives each beat into the tree. Accumulates cfg_groups tree results into one output-pixel sum, then emits that sum over a valid/ready handshake.
- Sits between the conv multiplier array and the activation/pooling stage.

Parameters:
- BIT_WIDTH, 8, width of one lane in an input beat.
- OUT_WIDTH, 8, width of the adder-tree result (signed).
- ACC_WIDTH, 16, accumulator and result width (signed, ACC_WIDTH >= OUT_WIDTH).
- GRP_W, 6, width of the group-count configuration.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_groups  input  GRP_W  beats per output pixel; sampled only on the first beat of a pixel.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  16*BIT_WIDTH  16 channel products; lane k is bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH].
- tree_in  output  16*BIT_WIDTH  operand bus to the adder tree.
- tree_sum  input  OUT_WIDTH  combinational signed sum returned by the adder tree.
- out_valid  output  1  out_data holds a completed pixel sum.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  ACC_WIDTH  accumulated signed sum.
- busy  output  1  a pixel is in progress or waiting to be drained.

Behaviour:
- The beat transfer condition is in_valid && in_ready. The output transfer condition is out_valid && out_ready.
- tree_in = in_data, combinationally, every cycle. The tree plus accumulate path completes in the same cycle a beat is accepted. No registers are placed in front of the tree.
- Synchronous reset takes priority over all other events:
  - state=IDLE, acc=0, grp_cnt=0, grp_tgt=1.
  - out_valid=0, out_data=0, in_ready=1, busy=0.
  - Reset mid-pixel discards the partial sum. Reset while out_valid=1 drops the pending result.
- Effective target = max(cfg_groups, 1); a value of 0 is treated as 1.
- Arithmetic:
  - tree_sum is sign-extended to ACC_WIDTH.
  - acc_next = acc + sext(tree_sum), with two's-complement wrap at ACC_WIDTH and no saturation.
- FSM states IDLE, ACCUM, DONE:
  - IDLE:
    - in_ready=1, busy=0.
    - On a transfer: latch grp_tgt = effective target; acc <= sext(tree_sum); grp_cnt <= 1.
    - If the target is 1: out_data <= sext(tree_sum), out_valid <= 1, go to DONE.
    - Otherwise go to ACCUM.
  - ACCUM:
    - in_ready=1, busy=1.
    - On a transfer: acc <= acc_next; grp_cnt <= grp_cnt+1.
    - When grp_cnt+1 == grp_tgt: out_data <= acc_next, out_valid <= 1, go to DONE.
    - With no transfer: hold all state; there is no timeout.
  - DONE:
    - in_ready=0, busy=1, out_valid=1.
    - out_data stays stable until transferred.
    - On an output transfer: out_valid <= 0, acc <= 0, grp_cnt <= 0, go to IDLE. The next beat is accepted no earlier than the following cycle.
- Latency:
  - out_valid rises in the cycle after the clock edge that accepted the final beat.
  - Minimum spacing between pixels is target+1 cycles, since DONE always costs one cycle.
- cfg_groups changes while busy=1 have no effect on the current pixel.
- in_valid while in DONE is back-pressured, never dropped.
- grp_cnt never exceeds grp_tgt. With grp_tgt = 2^GRP_W - 1 the count reaches that value with no overflow.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, busy=0, out_data=0.
- cfg_groups=4; tree_sum returns 10, 20, -5, 3 over 4 back-to-back beats -> out_valid rises on the next cycle with out_data=28. in_ready=0 until out_ready=1; IDLE is reached one cycle after the output transfer.
- cfg_groups=0, one beat with tree_sum=-7 -> treated as 1 group, out_data=16'hFFF9 one cycle later.
- cfg_groups=3, in_valid gaps between beats, out_ready held low 5 cycles -> sum correct, out_data stable, in_valid beats held off (in_ready=0) for all 5 cycles.
- ACC_WIDTH=8 override, cfg_groups=3, tree_sum=100 each -> out_data=8'sd44 (300 wraps mod 256).
- Reset asserted after 2 of 4 beats, then a fresh 2-group pixel with sums 1 and 2 -> out_data=3, with no residue from the aborted pixel.
